gx_wpar_slave: RTL

//  AXI4 write responder (slave) for the GX write-gather path: accepts fixed 128-bit incrementing write bursts of 1-MAX_BEATS

---
 rtl/gx_wpar_slave.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/gx_wpar_slave.sv
// AXI4 write responder for the GX write-gather path.
// Accepts INCR bursts of 16-byte beats and pushes each good beat into a small FIFO as
// {beat address, data}. Malformed bursts are drained without storing data and answered
// with SLVERR. One burst is in flight at a time; the B response does not wait for the FIFO
// to drain.
module gx_wpar_slave #(
  parameter int unsigned ADDR_W     = 49,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_BEATS  = 2
) (
  input  logic              clk,
  input  logic              reset,
  // AW channel
  input  logic [ADDR_W-1:0] awaddr_a,
  input  logic [7:0]        awlen_a,
  input  logic [2:0]        awsize_a,
  input  logic [1:0]        awburst_a,
  input  logic              awvalid_a,
  output logic              awready_a,
  // W channel
  input  logic [127:0]      wdata_a,
  input  logic [15:0]       wstrb_a,
  input  logic              wlast_a,
  input  logic              wvalid_a,
  output logic              wready_a,
  // B channel
  output logic [1:0]        bresp_a,
  output logic              bvalid_a,
  input  logic              bready_a,
  // Downstream stream
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        err_count
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned EntryW = ADDR_W + 128;

  typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        len_q, len_d;     // beats in burst, 1..256
  logic [7:0]        beat_q, beat_d;   // beats handshaken so far, saturating
  logic              bad_q, bad_d;
  logic [7:0]        err_q, err_d;

  // FIFO state
  logic [EntryW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic [EntryW-1:0] push_entry;

  logic              w_hs;
  logic              in_range;
  logic              at_last;
  logic              beat_ok;

  assign fifo_full = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign {out_addr, out_data} = mem_q[rd_ptr_q];
  assign err_count = err_q;

  // Beat address wraps silently at 2^ADDR_W.
  assign push_entry = {addr_q + ADDR_W'({beat_q, 4'b0000}), wdata_a};

  // Per-beat legality: in range, full strobes and wlast exactly on the final beat.
  assign in_range = ({1'b0, beat_q} < len_q);
  assign at_last  = ({1'b0, beat_q} == (len_q - 9'd1));
  assign beat_ok  = ~bad_q & in_range & (wstrb_a == 16'hFFFF) & (wlast_a == at_last);

  // Next-state and channel handshake outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    bad_d     = bad_q;
    err_d     = err_q;
    awready_a = 1'b0;
    wready_a  = 1'b0;
    bvalid_a  = 1'b0;
    bresp_a   = 2'b00;
    push      = 1'b0;
    w_hs      = 1'b0;

    unique case (state_q)
      StIdle: begin
        awready_a = 1'b1;
        if (awvalid_a) begin
          addr_d  = awaddr_a;
          len_d   = {1'b0, awlen_a} + 9'd1;
          beat_d  = 8'd0;
          bad_d   = (32'(awlen_a) >= MAX_BEATS) | (awsize_a != 3'd4) | (awburst_a != 2'd1);
          state_d = StData;
        end
      end
      StData: begin
        // Bad bursts are drained regardless of FIFO space; good ones see backpressure.
        wready_a = bad_q | ~fifo_full;
        w_hs     = wvalid_a & wready_a;
        if (w_hs) begin
          push = beat_ok;
          if (!beat_ok) bad_d = 1'b1;
          if (beat_q != 8'hFF) beat_d = beat_q + 8'd1;
          if (wlast_a) state_d = StResp;
        end
      end
      StResp: begin
        bvalid_a = 1'b1;
        bresp_a  = bad_q ? 2'b10 : 2'b00;
        if (bready_a) begin
          state_d = StIdle;
          if (bad_q && err_q != 8'hFF) err_d = err_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      bad_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
    end
  end

  // FIFO pointers and fill count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule
